// File: rtl/macu_vec_if.sv
// macu_vec_if: beat and result handshake bundle for macu_vec.
// slave = the MAC unit, master = the producer/consumer side.
interface macu_vec_if #(
  parameter int DW = 8,
  parameter int NL = 4,
  parameter int AW = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic             in_sgn;
  logic [NL*DW-1:0] xi;
  logic [NL*DW-1:0] wi;
  logic [AW-1:0]    bias;
  logic             out_valid;
  logic             out_ready;
  logic [AW-1:0]    co;
  logic             sat;

  modport slave (
    input  in_valid, in_first, in_last, in_sgn,
    input  xi, wi, bias, out_ready,
    output in_ready, out_valid, co, sat
  );

  modport master (
    output in_valid, in_first, in_last, in_sgn,
    output xi, wi, bias, out_ready,
    input  in_ready, out_valid, co, sat
  );
endinterface

// File: rtl/macu_vec.sv
// macu_vec: NL-lane dot-product MAC, products -> adder tree -> acc -> out.
// Optional MACU_SAT_EN: saturating accumulate with packet sat flag.
module macu_vec #(
  parameter int DW = 8,
  parameter int NL = 4,
  parameter int AW = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  macu_vec_if.slave io
);
  localparam int PW = 2 * DW;

  logic en;
  logic take;
  logic mode;
  logic sgn_b;

  assign en          = !io.out_valid || io.out_ready;
  assign io.in_ready = en;
  assign take        = io.in_valid && en;
  // Non-first beats reuse the mode latched at the packet's first beat.
  assign sgn_b       = io.in_first ? io.in_sgn : mode;

  logic [PW-1:0] pc [NL];

  for (genvar k = 0; k < NL; k++) begin : g_lane
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic [PW-1:0] xe;
    logic [PW-1:0] we;
    assign x     = io.xi[k*DW +: DW];
    assign w     = io.wi[k*DW +: DW];
    assign xe    = {{DW{sgn_b & x[DW-1]}}, x};
    assign we    = {{DW{sgn_b & w[DW-1]}}, w};
    assign pc[k] = xe * we;
  end

  logic [PW-1:0] p1 [NL];
  logic          v1, f1, l1, s1;
  logic [AW-1:0] b1;

  // Stage 1: lane products, beat tags, bias and mode capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      f1   <= 1'b0;
      l1   <= 1'b0;
      s1   <= 1'b0;
      b1   <= '0;
      mode <= 1'b0;
      for (int k = 0; k < NL; k++) p1[k] <= '0;
    end else if (en) begin
      v1 <= take;
      f1 <= take && io.in_first;
      l1 <= take && io.in_last;
      s1 <= sgn_b;
      if (take && io.in_first) begin
        b1   <= io.bias;
        mode <= io.in_sgn;
      end
      for (int k = 0; k < NL; k++) p1[k] <= pc[k];
    end
  end

  logic [AW-1:0] sc;

  // Lane sum, each product extended to AW according to mode.
  always_comb begin
    sc = '0;
    for (int k = 0; k < NL; k++)
      sc = sc + {{(AW-PW){s1 & p1[k][PW-1]}}, p1[k]};
  end

  logic          v2, f2, l2;
  logic [AW-1:0] b2;
  logic [AW-1:0] sm2;
`ifdef MACU_SAT_EN
  logic          sg2;
`endif

  // Stage 2: register the lane sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      f2  <= 1'b0;
      l2  <= 1'b0;
      b2  <= '0;
      sm2 <= '0;
`ifdef MACU_SAT_EN
      sg2 <= 1'b0;
`endif
    end else if (en) begin
      v2  <= v1;
      f2  <= f1;
      l2  <= l1;
      b2  <= b1;
      sm2 <= sc;
`ifdef MACU_SAT_EN
      sg2 <= s1;
`endif
    end
  end

  logic [AW-1:0] acc;
  logic [AW-1:0] base;
  logic [AW-1:0] sum;
  logic [AW-1:0] res;

  assign base = f2 ? b2 : acc;

`ifdef MACU_SAT_EN
  logic carry;
  logic ovf;
  logic psat;

  // Clamp on signed overflow or unsigned carry-out.
  always_comb begin
    {carry, sum} = {1'b0, base} + {1'b0, sm2};
    ovf = 1'b0;
    res = sum;
    if (sg2) begin
      ovf = (base[AW-1] == sm2[AW-1]) && (sum[AW-1] != base[AW-1]);
      if (ovf)
        res = base[AW-1] ? {1'b1, {(AW-1){1'b0}}}
                         : {1'b0, {(AW-1){1'b1}}};
    end else begin
      ovf = carry;
      if (ovf) res = '1;
    end
  end
`else
  assign sum = base + sm2;
  assign res = sum;
`endif

  logic v3, l3;

  // Stage 3: accumulate; first beat reseeds from bias.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      l3  <= 1'b0;
      acc <= '0;
`ifdef MACU_SAT_EN
      psat <= 1'b0;
`endif
    end else if (en) begin
      v3 <= v2;
      l3 <= v2 && l2;
      if (v2) begin
        acc <= res;
`ifdef MACU_SAT_EN
        psat <= f2 ? ovf : (psat | ovf);
`endif
      end
    end
  end

  // Output stage: hold result until taken; a new one may replace it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      io.out_valid <= 1'b0;
      io.co        <= '0;
`ifdef MACU_SAT_EN
      io.sat       <= 1'b0;
`endif
    end else if (en) begin
      if (v3 && l3) begin
        io.out_valid <= 1'b1;
        io.co        <= acc;
`ifdef MACU_SAT_EN
        io.sat       <= psat;
`endif
      end else begin
        io.out_valid <= 1'b0;
      end
    end
  end

`ifndef MACU_SAT_EN
  assign io.sat = 1'b0;
`endif
endmodule

// File: tb/tb_macu_vec.sv
// tb_macu_vec: directed vectors for macu_vec (AW=32 main, AW=20 wrap).
// Expected values are hand-computed dot products.
module tb_macu_vec;
  logic clk = 1'b0;
  logic rst_n;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  macu_vec_if #(.DW(8), .NL(4), .AW(32)) a ();
  macu_vec_if #(.DW(8), .NL(4), .AW(20)) b ();

  macu_vec #(.DW(8), .NL(4), .AW(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (a.slave)
  );

  macu_vec #(.DW(8), .NL(4), .AW(20)) u_w (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (b.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic f, input logic l, input logic s,
                      input logic [31:0] x, input logic [31:0] w,
                      input logic [31:0] bs);
    a.in_valid = 1'b1;
    a.in_first = f;
    a.in_last  = l;
    a.in_sgn   = s;
    a.xi       = x;
    a.wi       = w;
    a.bias     = bs;
    for (int i = 0; i < 20 && !a.in_ready; i++) @(negedge clk);
    if (!a.in_ready) chk("beat_ready", {31'b0, a.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    a.in_valid = 1'b0;
    a.in_first = 1'b0;
    a.in_last  = 1'b0;
  endtask

  task automatic wait_out(output logic [31:0] c, output logic s,
                          output int lat);
    lat = 0;
    while (!a.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    c = a.co;
    s = a.sat;
  endtask

  task automatic count(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (a.out_valid) p++;
    end
  endtask

  logic [31:0] c;
  logic        s;
  int          lat;
  int          p;

  initial begin
    rst_n       = 1'b0;
    a.out_ready = 1'b1;
    a.in_valid  = 1'b1;
    a.in_first  = 1'b1;
    a.in_last   = 1'b1;
    a.in_sgn    = 1'b0;
    a.xi        = 32'hFFFFFFFF;
    a.wi        = 32'hFFFFFFFF;
    a.bias      = 32'd10;
    b.out_ready = 1'b1;
    b.in_valid  = 1'b0;
    b.in_first  = 1'b0;
    b.in_last   = 1'b0;
    b.in_sgn    = 1'b0;
    b.xi        = '0;
    b.wi        = '0;
    b.bias      = '0;

    // reset held two edges with a valid beat present
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, a.out_valid}, 32'd0);
    chk("rst_co", a.co, 32'd0);
    chk("rst_sat", {31'b0, a.sat}, 32'd0);
    chk("rst_in_ready", {31'b0, a.in_ready}, 32'd1);
    rst_n = 1'b1;
    idle();
    count(6, p);
    chk("rst_no_out", p, 32'd0);

    // unsigned single beat: 4*255*255 + 10
    beat(1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd10);
    idle();
    wait_out(c, s, lat);
    chk("u1_latency", lat, 32'd3);
    chk("u1_co", c, 32'd260110);
    chk("u1_sat", {31'b0, s}, 32'd0);
    @(negedge clk);
    chk("u1_pulse", {31'b0, a.out_valid}, 32'd0);

    // lane packing: 1*5+2*6+3*7+4*8 = 70
    beat(1'b1, 1'b1, 1'b0, 32'h04030201, 32'h08070605, 32'd0);
    idle();
    wait_out(c, s, lat);
    chk("lanes_co", c, 32'd70);

    // signed 3-beat: 3*4*(-2*3) - 5 = -77; sgn on beat 2 ignored
    beat(1'b1, 1'b0, 1'b1, 32'hFEFEFEFE, 32'h03030303, 32'hFFFFFFFB);
    beat(1'b0, 1'b0, 1'b0, 32'hFEFEFEFE, 32'h03030303, 32'd0);
    beat(1'b0, 1'b1, 1'b0, 32'hFEFEFEFE, 32'h03030303, 32'd0);
    idle();
    wait_out(c, s, lat);
    chk("s3_co", c, 32'hFFFFFFB3);
    chk("s3_sat", {31'b0, s}, 32'd0);
    count(6, p);
    chk("s3_one_pulse", p, 32'd0);

    // backpressure: A = 100 + 4 + 4 = 108, B = 1000 + 24 = 1024
    a.out_ready = 1'b0;
    beat(1'b1, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 32'd100);
    beat(1'b0, 1'b1, 1'b0, 32'h01010101, 32'h01010101, 32'd0);
    beat(1'b1, 1'b1, 1'b0, 32'h02020202, 32'h03030303, 32'd1000);
    idle();
    wait_out(c, s, lat);
    chk("bp_first_co", c, 32'd108);
    repeat (3) @(negedge clk);
    chk("bp_in_ready", {31'b0, a.in_ready}, 32'd0);
    chk("bp_held_valid", {31'b0, a.out_valid}, 32'd1);
    chk("bp_held_co", a.co, 32'd108);
    a.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_second_valid", {31'b0, a.out_valid}, 32'd1);
    chk("bp_second_co", a.co, 32'd1024);
    @(negedge clk);
    chk("bp_drain", {31'b0, a.out_valid}, 32'd0);

    // restart: new first discards 800+7, signed mode from new first
    beat(1'b1, 1'b0, 1'b0, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'd7);
    beat(1'b0, 1'b0, 1'b0, 32'h0A0A0A0A, 32'h0A0A0A0A, 32'd0);
    beat(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h05050505, 32'd3);
    beat(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h05050505, 32'd0);
    idle();
    wait_out(c, s, lat);
    chk("restart_co", c, 32'hFFFFFFDB);
    count(6, p);
    chk("restart_one_pulse", p, 32'd0);

    // reset mid-packet drops the partial sum
    beat(1'b1, 1'b0, 1'b0, 32'h01010101, 32'h01010101, 32'd50);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count(8, p);
    chk("midrst_no_out", p, 32'd0);
    beat(1'b1, 1'b1, 1'b0, 32'h01010101, 32'h01010101, 32'd0);
    idle();
    wait_out(c, s, lat);
    chk("post_rst_co", c, 32'd4);

    // AW=20 signed: 524287 + 1
    b.in_valid = 1'b1;
    b.in_first = 1'b1;
    b.in_last  = 1'b1;
    b.in_sgn   = 1'b1;
    b.xi       = 32'h00000001;
    b.wi       = 32'h00000001;
    b.bias     = 20'h7FFFF;
    @(negedge clk);
    b.in_valid = 1'b0;
    lat = 0;
    while (!b.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("wrap_latency", lat, 32'd3);
`ifdef MACU_SAT_EN
    chk("wrap_co", {12'b0, b.co}, 32'h7FFFF);
    chk("wrap_sat", {31'b0, b.sat}, 32'd1);
`else
    chk("wrap_co", {12'b0, b.co}, 32'h80000);
    chk("wrap_sat", {31'b0, b.sat}, 32'd0);
`endif

    // next packet: flag cleared, 0 + 1
    b.in_valid = 1'b1;
    b.bias     = 20'h0;
    @(negedge clk);
    b.in_valid = 1'b0;
    lat = 0;
    while (!b.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w2_co", {12'b0, b.co}, 32'd1);
    chk("w2_sat", {31'b0, b.sat}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
